slow_window: RTL

- Consumes the slow-peripheral configuration flags and the 4-bit timeout produced by the configuration-latch stage.
- On each new bus access to a region whose slow flag is set, asserts a slowdown request to the accelerator clock-switch logic.
- Holds that request for the duration of the access, then for a post-access countdown of SlowTimeout ticks.
- Also generates a registered clock-gate request when SlowClockGate is set.

---
 rtl/slow_window_if.sv | 37 +++
 rtl/slow_window.sv | 116 +++++++++++
 2 files changed

// File: rtl/slow_window_if.sv
// Bus-side signals for slow_window: access decodes, configuration-latch flags,
// timebase strobe, and the registered slowdown/clock-gate requests.
interface slow_window_if;
  logic       BACT;
  logic       IACKCS;
  logic       VIACS;
  logic       IWMCS;
  logic       SCCCS;
  logic       SCSICS;
  logic       SndCS;
  logic       SlowIACK;
  logic       SlowVIA;
  logic       SlowIWM;
  logic       SlowSCC;
  logic       SlowSCSI;
  logic       SlowSnd;
  logic       SlowClockGate;
  logic [3:0] SlowTimeout;
  logic       TimeTick;
  logic       Slow;
  logic       ClockGate;
  logic [3:0] SlowCnt;

  modport master (
    output BACT, IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS,
    output SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd,
    output SlowClockGate, SlowTimeout, TimeTick,
    input  Slow, ClockGate, SlowCnt
  );

  modport slave (
    input  BACT, IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS,
    input  SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd,
    input  SlowClockGate, SlowTimeout, TimeTick,
    output Slow, ClockGate, SlowCnt
  );
endinterface

// File: rtl/slow_window.sv
// Slowdown window: requests a slow clock for slow-flagged accesses plus a post-access
// tick countdown. Macro SLOW_TICK_PRESCALE_EN replaces TimeTick with an internal prescaler.
module slow_window #(
  parameter int unsigned TICK_DIV = 16
) (
  input  logic         CLK,
  input  logic         POR,
  slow_window_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_HOLD
  } state_e;

  state_e     state_q, state_d;
  logic       bactr_q;
  logic [3:0] cnt_q, cnt_d;
  logic       slow_q, slow_d;
  logic       cg_q, cg_d;
  logic       start, hit, trigger, tick;

  if (TICK_DIV < 2 || TICK_DIV > 256) begin : g_bad_tick_div
    $error("slow_window: TICK_DIV out of range 2..256");
  end

`ifdef SLOW_TICK_PRESCALE_EN
  localparam logic [7:0] PreLast = 8'(TICK_DIV - 1);

  logic [7:0] pre_q, pre_d;

  always_comb begin
    pre_d = (pre_q == PreLast) ? '0 : pre_q + 8'd1;
  end

  always_ff @(posedge CLK) begin
    if (POR) pre_q <= '0;
    else     pre_q <= pre_d;
  end

  assign tick = (pre_q == PreLast);
`else
  assign tick = bus.TimeTick;
`endif

  assign start   = bus.BACT && !bactr_q;
  assign hit     = (bus.IACKCS && bus.SlowIACK) || (bus.VIACS  && bus.SlowVIA)  ||
                   (bus.IWMCS  && bus.SlowIWM)  || (bus.SCCCS  && bus.SlowSCC)  ||
                   (bus.SCSICS && bus.SlowSCSI) || (bus.SndCS  && bus.SlowSnd);
  assign trigger = start && hit;

  always_ff @(posedge CLK) begin
    if (POR) begin
      state_q <= S_IDLE;
      bactr_q <= 1'b0;
      cnt_q   <= '0;
      slow_q  <= 1'b0;
      cg_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bactr_q <= bus.BACT;
      cnt_q   <= cnt_d;
      slow_q  <= slow_d;
      cg_q    <= cg_d;
    end
  end

  // A retrigger in HOLD keeps the count; the reload happens when that access ends.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (trigger) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (!bus.BACT) begin
          if (bus.SlowTimeout == '0) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = S_HOLD;
            cnt_d   = bus.SlowTimeout;
          end
        end
      end
      S_HOLD: begin
        if (trigger) begin
          state_d = S_ACCESS;
        end else if (tick) begin
          if (cnt_q == 4'd1) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    slow_d = (state_d != S_IDLE);
    cg_d   = slow_d && bus.SlowClockGate;
  end

  assign bus.Slow      = slow_q;
  assign bus.ClockGate = cg_q;
  assign bus.SlowCnt   = cnt_q;

endmodule
